// File: rtl/writeback_stage.sv
// ============================================================================
//  Module   : writeback_stage
//  Purpose  : RV64I final pipeline stage. It captures retiring instructions,
//             waits for load responses, aligns and extends the load data, and
//             drives the register-file write port.
//  Options  : define WB_INSTRET_EN to add the 64-bit retired-instruction
//             counter output instret_o.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            mem_valid_i,
    input  logic [4:0]      mem_rd_idx_i,
    input  logic            mem_reg_write_i,
    input  logic            mem_is_load_i,
    input  logic [2:0]      mem_funct3_i,
    input  logic [2:0]      mem_addr_lsb_i,
    input  logic [XLEN-1:0] mem_result_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            stall_o,
    output logic [4:0]      rd_idx_o,
    output logic [XLEN-1:0] wr_data_o,
    output logic            wr_en_o,
    output logic            retire_o
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]     instret_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LOAD = 2'd1,
        ST_LOAD_WB   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic [4:0]        rd_idx_q, rd_idx_d;
    logic              reg_write_q, reg_write_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [2:0]        addr_lsb_q, addr_lsb_d;
    logic [XLEN-1:0]   data_q, data_d;

    logic [XLEN-1:0]   load_shifted;
    logic [XLEN-1:0]   load_ext;
    logic              complete;

    // The response is doubleword-aligned; move the addressed byte to bit 0
    // and let the top fill with zeros for misaligned accesses.
    always_comb begin
        load_shifted = dmem_rdata_i >> {addr_lsb_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{(XLEN-8){load_shifted[7]}},   load_shifted[7:0]};
            3'b001:  load_ext = {{(XLEN-16){load_shifted[15]}}, load_shifted[15:0]};
            3'b010:  load_ext = {{(XLEN-32){load_shifted[31]}}, load_shifted[31:0]};
            3'b100:  load_ext = {{(XLEN-8){1'b0}},              load_shifted[7:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}},             load_shifted[15:0]};
            3'b110:  load_ext = {{(XLEN-32){1'b0}},             load_shifted[31:0]};
            default: load_ext = load_shifted;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        rd_idx_d    = rd_idx_q;
        reg_write_d = reg_write_q;
        funct3_d    = funct3_q;
        addr_lsb_d  = addr_lsb_q;
        data_d      = data_q;

        if (state_q != ST_WAIT_LOAD) begin
            valid_d     = mem_valid_i;
            rd_idx_d    = mem_rd_idx_i;
            reg_write_d = mem_reg_write_i;
            funct3_d    = mem_funct3_i;
            addr_lsb_d  = mem_addr_lsb_i;
            data_d      = mem_result_i;
            state_d     = (mem_valid_i && mem_is_load_i) ? ST_WAIT_LOAD : ST_IDLE;
        end else if (dmem_rvalid_i) begin
            data_d  = load_ext;
            state_d = ST_LOAD_WB;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            valid_q     <= 1'b0;
            rd_idx_q    <= 5'd0;
            reg_write_q <= 1'b0;
            funct3_q    <= 3'd0;
            addr_lsb_q  <= 3'd0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            rd_idx_q    <= rd_idx_d;
            reg_write_q <= reg_write_d;
            funct3_q    <= funct3_d;
            addr_lsb_q  <= addr_lsb_d;
            data_q      <= data_d;
        end
    end

    // Outputs decode from registered state only, so stall_o never sees rvalid.
    assign complete  = ((state_q == ST_IDLE) && valid_q) || (state_q == ST_LOAD_WB);
    assign stall_o   = (state_q == ST_WAIT_LOAD);
    assign retire_o  = complete;
    assign wr_en_o   = complete && reg_write_q && (rd_idx_q != 5'd0);
    assign rd_idx_o  = rd_idx_q;
    assign wr_data_o = data_q;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    always_comb begin
        instret_d = instret_q;
        if (complete) begin
            instret_d = instret_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instret_q <= 64'd0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret_o = instret_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// ============================================================================
//  Module   : tb_writeback_stage
//  Purpose  : Directed self-checking bench for writeback_stage, including a
//             small register-file model written on the negedge.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_stage;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic        mem_rw;
    logic        mem_ld;
    logic [2:0]  mem_f3;
    logic [2:0]  mem_lsb;
    logic [63:0] mem_res;
    logic        rvalid;
    logic [63:0] rdata;
    logic        stall_o;
    logic [4:0]  rd_idx_o;
    logic [63:0] wr_data_o;
    logic        wr_en_o;
    logic        retire_o;
`ifdef WB_INSTRET_EN
    logic [63:0] instret_o;
`endif

    logic [63:0] rf [32];
    int          n_chk;
    int          n_err;

    writeback_stage #(.XLEN(64)) u_dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .mem_valid_i     (mem_valid),
        .mem_rd_idx_i    (mem_rd),
        .mem_reg_write_i (mem_rw),
        .mem_is_load_i   (mem_ld),
        .mem_funct3_i    (mem_f3),
        .mem_addr_lsb_i  (mem_lsb),
        .mem_result_i    (mem_res),
        .dmem_rvalid_i   (rvalid),
        .dmem_rdata_i    (rdata),
        .stall_o         (stall_o),
        .rd_idx_o        (rd_idx_o),
        .wr_data_o       (wr_data_o),
        .wr_en_o         (wr_en_o),
        .retire_o        (retire_o)
`ifdef WB_INSTRET_EN
        ,
        .instret_o       (instret_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 64'd0;
    end

    always @(negedge clk) begin
        if (wr_en_o) rf[rd_idx_o] <= wr_data_o;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle;
        mem_valid = 1'b0;
        mem_rd    = 5'd0;
        mem_rw    = 1'b0;
        mem_ld    = 1'b0;
        mem_f3    = 3'd0;
        mem_lsb   = 3'd0;
        mem_res   = 64'd0;
        rvalid    = 1'b0;
        rdata     = 64'd0;
    endtask

    task automatic set_alu(input logic [4:0] rd, input logic [63:0] res);
        mem_valid = 1'b1;
        mem_rd    = rd;
        mem_rw    = 1'b1;
        mem_ld    = 1'b0;
        mem_f3    = 3'd0;
        mem_lsb   = 3'd0;
        mem_res   = res;
        rvalid    = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] lsb);
        mem_valid = 1'b1;
        mem_rd    = rd;
        mem_rw    = 1'b1;
        mem_ld    = 1'b1;
        mem_f3    = f3;
        mem_lsb   = lsb;
        mem_res   = 64'hDEAD_BEEF_DEAD_BEEF;
        rvalid    = 1'b0;
    endtask

    // Runs one load with rvalid after `waits` stall cycles and checks the result.
    task automatic run_load(input string tag, input logic [2:0] f3, input logic [2:0] lsb,
                            input logic [63:0] data, input int waits, input logic [63:0] exp);
        set_load(5'd10, f3, lsb);
        tick;
        for (int w = 0; w < waits; w++) begin
            check({tag, "_stall"}, {63'd0, stall_o}, 64'd1);
            check({tag, "_noret"}, {63'd0, retire_o}, 64'd0);
            if (w == waits - 1) begin
                rvalid = 1'b1;
                rdata  = data;
            end
            tick;
        end
        check({tag, "_data"}, wr_data_o, exp);
        check({tag, "_wen"}, {63'd0, wr_en_o}, 64'd1);
        check({tag, "_unstall"}, {63'd0, stall_o}, 64'd0);
        set_idle;
        tick;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        set_idle;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", {63'd0, stall_o}, 64'd0);
        check("rst_wen", {63'd0, wr_en_o}, 64'd0);
        check("rst_retire", {63'd0, retire_o}, 64'd0);
        check("rst_rd", {59'd0, rd_idx_o}, 64'd0);
        check("rst_data", wr_data_o, 64'd0);
`ifdef WB_INSTRET_EN
        check("rst_instret", instret_o, 64'd0);
`endif
        rst_n = 1'b1;

        // Single ALU write
        set_alu(5'd5, 64'h1234);
        tick;
        check("alu_wen", {63'd0, wr_en_o}, 64'd1);
        check("alu_rd", {59'd0, rd_idx_o}, 64'd5);
        check("alu_data", wr_data_o, 64'h1234);
        check("alu_retire", {63'd0, retire_o}, 64'd1);
        set_idle;
        tick;
        check("alu_rf5", rf[5], 64'h1234);
        check("alu_idle_wen", {63'd0, wr_en_o}, 64'd0);

        // Back-to-back non-loads
        for (int i = 1; i <= 3; i++) begin
            set_alu(5'(i), 64'h100 + 64'(i));
            tick;
            check("b2b_wen", {63'd0, wr_en_o}, 64'd1);
            check("b2b_rd", {59'd0, rd_idx_o}, 64'(i));
            check("b2b_stall", {63'd0, stall_o}, 64'd0);
        end
        set_idle;
        tick;
        check("b2b_rf3", rf[3], 64'h103);

        run_load("lb",  3'b000, 3'd3, 64'h0000_0000_80FF_0000, 2, 64'hFFFF_FFFF_FFFF_FF80);
        run_load("lbu", 3'b100, 3'd3, 64'h0000_0000_80FF_0000, 2, 64'h0000_0000_0000_0080);
        run_load("lw",  3'b010, 3'd4, 64'h89AB_CDEF_0000_0000, 1, 64'hFFFF_FFFF_89AB_CDEF);
        run_load("lwu", 3'b110, 3'd4, 64'h89AB_CDEF_0000_0000, 1, 64'h0000_0000_89AB_CDEF);
        run_load("lh",  3'b001, 3'd2, 64'h0000_0000_8001_0000, 1, 64'hFFFF_FFFF_FFFF_8001);
        run_load("ld",  3'b011, 3'd0, 64'h0123_4567_89AB_CDEF, 1, 64'h0123_4567_89AB_CDEF);
        run_load("f7",  3'b111, 3'd1, 64'h0123_4567_89AB_CDEF, 1, 64'h0001_2345_6789_ABCD);
        check("ld_rf10", rf[10], 64'h0001_2345_6789_ABCD);

        // Load presented in the LOAD_WB cycle goes straight back to waiting
        set_load(5'd11, 3'b011, 3'd0);
        tick;
        rvalid = 1'b1;
        rdata  = 64'h1111_2222_3333_4444;
        tick;
        check("chain_wb1", wr_data_o, 64'h1111_2222_3333_4444);
        set_load(5'd12, 3'b100, 3'd0);
        rvalid = 1'b0;
        tick;
        check("chain_stall", {63'd0, stall_o}, 64'd1);
        rvalid = 1'b1;
        rdata  = 64'h0000_0000_0000_00A5;
        tick;
        check("chain_wb2", wr_data_o, 64'h0000_0000_0000_00A5);
        check("chain_rd2", {59'd0, rd_idx_o}, 64'd12);
        set_idle;
        tick;

        // Stray rvalid while idle
        rvalid = 1'b1;
        rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        tick;
        check("stray_stall", {63'd0, stall_o}, 64'd0);
        check("stray_retire", {63'd0, retire_o}, 64'd0);
        set_idle;

        // Write to x0
        set_alu(5'd0, 64'hDEAD);
        tick;
        check("x0_wen", {63'd0, wr_en_o}, 64'd0);
        check("x0_retire", {63'd0, retire_o}, 64'd1);
        set_idle;
        tick;
        check("x0_rf0", rf[0], 64'd0);

        // Reset while waiting for a load
        set_load(5'd7, 3'b011, 3'd0);
        tick;
        check("rw_stall_pre", {63'd0, stall_o}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rw_stall_rst", {63'd0, stall_o}, 64'd0);
        set_idle;
        rst_n  = 1'b1;
        rvalid = 1'b1;
        rdata  = 64'h7777_7777_7777_7777;
        tick;
        check("rw_wen", {63'd0, wr_en_o}, 64'd0);
        check("rw_stall", {63'd0, stall_o}, 64'd0);
        check("rw_retire", {63'd0, retire_o}, 64'd0);
        rvalid = 1'b0;
        tick;
        check("rw_rf7", rf[7], 64'd0);
`ifdef WB_INSTRET_EN
        check("rw_instret", instret_o, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
